riot_gen: RTL and testbench

Parametrised RIOT-class peripheral: a RAM block, `NPORTS` 8-bit bidirectional ports and `NTIMERS` independent interval timers behind one CPU bus.
- Successor to the single-timer, two-port RIOT used by the IEEE drive and CBM-II cores.
- Adds per-timer auto-reload mode, per-timer run control, per-port selectable bit-7 edge interrupts and write-1-to-clear interrupt flags.
- Sits on the drive/system CPU bus and is clocked with PHI2 plus a clock enable.

---
 rtl/riot_gen_pkg.sv | 59 +++++
 rtl/riot_gen_timer.sv | 112 +++++++++++
 rtl/riot_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_riot_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riot_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riot_gen_pkg
// Description : Shared definitions for the riot_gen peripheral: I/O register
//               offsets, reset values, the timer prescale encoding and the
//               helpers that map a prescale selection / channel index onto
//               shift amounts and bus addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package riot_gen_pkg;

    // I/O map (RS_n = 1)
    localparam logic [7:0] C_PORT_BASE  = 8'h00;   // OUT_p at +2p, DDR_p at +2p+1
    localparam logic [7:0] C_TMR_BASE   = 8'h10;   // CNT_t at +4t, CTRL_t at +4t+1
    localparam logic [7:0] C_FLAG_ADDR  = 8'h20;
    localparam logic [7:0] C_IEN_ADDR   = 8'h21;
    localparam logic [7:0] C_EDGE_ADDR  = 8'h22;

    // Timer reset values
    localparam logic [7:0] C_CNT_RESET  = 8'hFF;
    localparam logic [3:0] C_CTRL_RESET = 4'hA;    // /64, mode 0, running

    typedef enum logic [1:0] {
        PRESC_1    = 2'd0,
        PRESC_8    = 2'd1,
        PRESC_64   = 2'd2,
        PRESC_1024 = 2'd3
    } prescale_e;

    // Number of low prescaler bits that must be zero for a tick.
    function automatic logic [3:0] prescale_shift(input prescale_e p);
        logic [3:0] k;
        case (p)
            PRESC_1:  k = 4'd0;
            PRESC_8:  k = 4'd3;
            PRESC_64: k = 4'd6;
            default:  k = 4'd10;
        endcase
        return k;
    endfunction

    function automatic logic [7:0] port_out_addr(input int unsigned p);
        return C_PORT_BASE + 8'(2 * p);
    endfunction

    function automatic logic [7:0] port_ddr_addr(input int unsigned p);
        return C_PORT_BASE + 8'(2 * p + 1);
    endfunction

    function automatic logic [7:0] tmr_cnt_addr(input int unsigned t);
        return C_TMR_BASE + 8'(4 * t);
    endfunction

    function automatic logic [7:0] tmr_ctrl_addr(input int unsigned t);
        return C_TMR_BASE + 8'(4 * t + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riot_gen_timer.sv
`default_nettype none
// ============================================================================
// Module      : riot_gen_timer
// Description : One interval-timer channel: 8-bit count, reload latch,
//               10-bit free prescaler, rollover state and CTRL register.
//               Produces a one-cycle flag-set pulse on underflow.
// Ports       : clk, res_n      - clock, synchronous active-low reset
//               ce_i            - clock enable
//               cnt_we_i        - CNT write strobe (already qualified by ce)
//               ctrl_we_i       - CTRL write strobe (already qualified by ce)
//               wdata_i[7:0]    - write data
//               count_o[7:0]    - current count
//               ctrl_o[3:0]     - {run, reload, prescale[1:0]}
//               flag_set_o      - underflow pulse for the interrupt flag
// Revision    : 1.0 - initial release
// ============================================================================
module riot_gen_timer
    import riot_gen_pkg::*;
(
    input  logic       clk,
    input  logic       res_n,
    input  logic       ce_i,
    input  logic       cnt_we_i,
    input  logic       ctrl_we_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] count_o,
    output logic [3:0] ctrl_o,
    output logic       flag_set_o
);

    logic [7:0] count_q, count_d;
    logic [7:0] latch_q, latch_d;
    logic [3:0] ctrl_q,  ctrl_d;
    logic [9:0] presc_q, presc_d;
    logic       roll_q,  roll_d;

    prescale_e  presc_sel;
    logic [9:0] presc_mask;
    logic       run;
    logic       reload;
    logic       tick;

    always_comb begin
        presc_sel  = prescale_e'(ctrl_q[1:0]);
        reload     = ctrl_q[2];
        run        = ctrl_q[3];
        // (1 << 10) wraps to 0 in 10 bits, so /1024 yields an all-ones mask.
        presc_mask = (10'd1 << prescale_shift(presc_sel)) - 10'd1;
        tick       = ce_i & run & (roll_q | ((presc_q & presc_mask) == 10'd0));

        count_d    = count_q;
        latch_d    = latch_q;
        ctrl_d     = ctrl_q;
        presc_d    = presc_q;
        roll_d     = roll_q;
        flag_set_o = 1'b0;

        if (ce_i && run) begin
            presc_d = presc_q + 10'd1;
        end

        if (tick) begin
            if (count_q == 8'h00) begin
                flag_set_o = 1'b1;
                if (reload) begin
                    count_d = latch_q;
                end else begin
                    // Classic RIOT behaviour: keep counting every ce past zero.
                    count_d = 8'hFF;
                    roll_d  = 1'b1;
                end
            end else begin
                count_d = count_q - 8'd1;
            end
        end

        if (ctrl_we_i) begin
            ctrl_d = wdata_i[3:0];
        end

        // A CNT write overrides any same-cycle tick and suppresses the
        // underflow flag, so software always restarts from a clean state.
        if (cnt_we_i) begin
            count_d    = wdata_i;
            latch_d    = wdata_i;
            presc_d    = 10'd0;
            roll_d     = 1'b0;
            flag_set_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            count_q <= C_CNT_RESET;
            latch_q <= C_CNT_RESET;
            ctrl_q  <= C_CTRL_RESET;
            presc_q <= 10'd0;
            roll_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            latch_q <= latch_d;
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            roll_q  <= roll_d;
        end
    end

    assign count_o = count_q;
    assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/riot_gen.sv
`default_nettype none
// ============================================================================
// Module      : riot_gen
// Description : Parametrised RIOT-class peripheral: RAM, NPORTS 8-bit ports
//               with data-direction registers, NTIMERS interval timers,
//               bit-7 edge detection and a W1C interrupt flag register.
// Ports       : clk, res_n      - PHI2 clock, synchronous active-low reset
//               ce              - clock enable for all state except d_out
//               addr, RW_n, d_in, RS_n, CS1, CS2_n - CPU bus inputs
//               d_out, oe       - registered read data and its enable
//               IRQ_n           - active-low interrupt
//               P_in, P_out     - port pins, port p on bits [8p+7:8p]
// Revision    : 1.0 - initial release
// ============================================================================
module riot_gen
    import riot_gen_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int NTIMERS = 2,
    parameter int RAMSIZE = 128
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                ce,
    input  logic [7:0]          addr,
    input  logic                RW_n,
    input  logic [7:0]          d_in,
    output logic [7:0]          d_out,
    output logic                oe,
    input  logic                RS_n,
    input  logic                CS1,
    input  logic                CS2_n,
    output logic                IRQ_n,
    input  logic [NPORTS*8-1:0] P_in,
    output logic [NPORTS*8-1:0] P_out
);

    localparam int         AW        = $clog2(RAMSIZE);
    localparam logic [7:0] FLAG_IMPL = 8'(((1 << NPORTS) - 1) << 4)
                                     | 8'((1 << NTIMERS) - 1);

    logic               sel;
    logic               rd;
    logic               io_wr;
    logic               ram_wr;

    logic [7:0]         ram_q  [RAMSIZE];
    logic [7:0]         out_q  [NPORTS];
    logic [7:0]         ddr_q  [NPORTS];
    logic [NPORTS-1:0]  prev7_q;
    logic [NPORTS-1:0]  edge_set;

    logic [7:0]         flag_q, flag_d;
    logic [7:0]         ien_q;
    logic [7:0]         edge_q;
    logic [7:0]         dout_q, dout_d;

    logic [7:0]         tmr_count [NTIMERS];
    logic [3:0]         tmr_ctrl  [NTIMERS];
    logic [NTIMERS-1:0] tmr_set;
    logic [NTIMERS-1:0] cnt_we;
    logic [NTIMERS-1:0] ctrl_we;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign sel    = CS1 & ~CS2_n;
    assign rd     = sel & RW_n;
    assign io_wr  = ce & sel & ~RW_n &  RS_n;
    assign ram_wr = ce & sel & ~RW_n & ~RS_n;
    assign oe     = rd;

    // ------------------------------------------------------------------
    // Timers
    // ------------------------------------------------------------------
    for (genvar t = 0; t < NTIMERS; t++) begin : g_timer
        assign cnt_we[t]  = io_wr & (addr == tmr_cnt_addr(t));
        assign ctrl_we[t] = io_wr & (addr == tmr_ctrl_addr(t));

        riot_gen_timer u_timer (
            .clk        (clk),
            .res_n      (res_n),
            .ce_i       (ce),
            .cnt_we_i   (cnt_we[t]),
            .ctrl_we_i  (ctrl_we[t]),
            .wdata_i    (d_in),
            .count_o    (tmr_count[t]),
            .ctrl_o     (tmr_ctrl[t]),
            .flag_set_o (tmr_set[t])
        );
    end

    // ------------------------------------------------------------------
    // Ports and bit-7 edge detection
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        // Input-configured bits float high through the modelled pull-up.
        assign P_out[8*p +: 8] = out_q[p] | ~ddr_q[p];
        assign edge_set[p]     = ce & (edge_q[p] ? (~prev7_q[p] &  P_in[8*p+7])
                                                 : ( prev7_q[p] & ~P_in[8*p+7]));
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int p = 0; p < NPORTS; p++) begin
                out_q[p] <= 8'h00;
                ddr_q[p] <= 8'h00;
            end
            // Pins idle high after reset, so start the history high too.
            prev7_q <= '1;
        end else if (ce) begin
            for (int p = 0; p < NPORTS; p++) begin
                prev7_q[p] <= P_in[8*p+7];
                if (io_wr && (addr == port_out_addr(p))) begin
                    out_q[p] <= d_in;
                end
                if (io_wr && (addr == port_ddr_addr(p))) begin
                    ddr_q[p] <= d_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt flags: W1C first, then CNT-write clears, then new events,
    // so a same-cycle set always survives a software clear.
    // ------------------------------------------------------------------
    always_comb begin
        flag_d = flag_q;
        if (io_wr && (addr == C_FLAG_ADDR)) begin
            flag_d = flag_d & ~d_in;
        end
        for (int t = 0; t < NTIMERS; t++) begin
            if (cnt_we[t]) begin
                flag_d[t] = 1'b0;
            end
        end
        for (int t = 0; t < NTIMERS; t++) begin
            if (tmr_set[t]) begin
                flag_d[t] = 1'b1;
            end
        end
        for (int p = 0; p < NPORTS; p++) begin
            if (edge_set[p]) begin
                flag_d[4+p] = 1'b1;
            end
        end
        flag_d = flag_d & FLAG_IMPL;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            flag_q <= 8'h00;
            ien_q  <= 8'h00;
            edge_q <= 8'h00;
        end else begin
            flag_q <= flag_d;
            if (io_wr && (addr == C_IEN_ADDR)) begin
                ien_q <= d_in;
            end
            if (io_wr && (addr == C_EDGE_ADDR)) begin
                edge_q <= d_in;
            end
        end
    end

    assign IRQ_n = ~|(flag_q & ien_q);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int i = 0; i < RAMSIZE; i++) begin
                ram_q[i] <= 8'h00;
            end
        end else if (ram_wr) begin
            ram_q[addr[AW-1:0]] <= d_in;
        end
    end

    // ------------------------------------------------------------------
    // Read mux; d_out captures on any selected read regardless of ce.
    // ------------------------------------------------------------------
    always_comb begin
        dout_d = 8'h00;
        if (!RS_n) begin
            dout_d = ram_q[addr[AW-1:0]];
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (addr == port_out_addr(p)) begin
                    dout_d = P_in[8*p +: 8] & P_out[8*p +: 8];
                end
                if (addr == port_ddr_addr(p)) begin
                    dout_d = ddr_q[p];
                end
            end
            for (int t = 0; t < NTIMERS; t++) begin
                if (addr == tmr_cnt_addr(t)) begin
                    dout_d = tmr_count[t];
                end
                if (addr == tmr_ctrl_addr(t)) begin
                    dout_d = {4'b0000, tmr_ctrl[t]};
                end
            end
            if (addr == C_FLAG_ADDR) begin
                dout_d = flag_q;
            end
            if (addr == C_IEN_ADDR) begin
                dout_d = ien_q;
            end
            if (addr == C_EDGE_ADDR) begin
                dout_d = edge_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            dout_q <= 8'hFF;
        end else if (rd) begin
            dout_q <= dout_d;
        end
    end

    assign d_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_riot_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_riot_gen
// Description : Self-checking bench for riot_gen (default parameters).
//               Bus reads push their expected data into a queue; a monitor
//               pops and compares whenever the DUT captures read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riot_gen;

    logic        clk = 1'b0;
    logic        res_n;
    logic        ce;
    logic [7:0]  addr;
    logic        RW_n;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        oe;
    logic        RS_n;
    logic        CS1;
    logic        CS2_n;
    logic        IRQ_n;
    logic [15:0] P_in;
    logic [15:0] P_out;
    logic [15:0] ext_and;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q [$];
    string       name_q [$];

    // Pins fed back, with individual bits optionally pulled low externally.
    assign P_in = P_out & ext_and;

    always #5 clk = ~clk;

    riot_gen #(
        .NPORTS  (2),
        .NTIMERS (2),
        .RAMSIZE (128)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .ce    (ce),
        .addr  (addr),
        .RW_n  (RW_n),
        .d_in  (d_in),
        .d_out (d_out),
        .oe    (oe),
        .RS_n  (RS_n),
        .CS1   (CS1),
        .CS2_n (CS2_n),
        .IRQ_n (IRQ_n),
        .P_in  (P_in),
        .P_out (P_out)
    );

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic bus_wr(input logic rs, input logic [7:0] a, input logic [7:0] d);
        RS_n = rs; addr = a; d_in = d; RW_n = 1'b0; CS1 = 1'b1; CS2_n = 1'b0;
        @(negedge clk);
        CS1 = 1'b0; CS2_n = 1'b1; RW_n = 1'b1;
    endtask

    task automatic bus_rd(input logic rs, input logic [7:0] a, input logic [7:0] e, input string n);
        RS_n = rs; addr = a; RW_n = 1'b1; CS1 = 1'b1; CS2_n = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        CS1 = 1'b0; CS2_n = 1'b1;
    endtask

    task automatic wio(input logic [7:0] a, input logic [7:0] d);
        bus_wr(1'b1, a, d);
    endtask

    task automatic rio(input logic [7:0] a, input logic [7:0] e, input string n);
        bus_rd(1'b1, a, e, n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a selected read at a rising edge loads d_out at that edge.
    initial begin
        logic [7:0] e;
        string      n;
        forever begin
            @(posedge clk);
            if (oe) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read: got %h expected none", d_out);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (d_out !== e) begin
                        failures++;
                        $display("FAIL %s: got %h expected %h", n, d_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n = 1'b0; ce = 1'b1; addr = 8'h00; RW_n = 1'b1; d_in = 8'h00;
        RS_n = 1'b1; CS1 = 1'b0; CS2_n = 1'b1; ext_and = 16'hFFFF;

        // ---------------- reset defaults (ce low freezes timers) -------
        idle(3);
        res_n = 1'b1; ce = 1'b0;
        check("rst_dout", {8'h00, d_out}, 16'h00FF);
        check("rst_irq",  {15'd0, IRQ_n}, 16'h0001);
        check("rst_pout", P_out, 16'hFFFF);
        rio(8'h10, 8'hFF, "rst_cnt0");
        rio(8'h11, 8'h0A, "rst_ctrl0");
        rio(8'h14, 8'hFF, "rst_cnt1");
        rio(8'h20, 8'h00, "rst_flag");
        bus_rd(1'b0, 8'h05, 8'h00, "rst_ram");
        wio(8'h21, 8'hFF);                 // ignored: ce low
        rio(8'h21, 8'h00, "ien_no_ce");
        ce = 1'b1;

        // ---------------- timer0 one-shot /8 ---------------------------
        wio(8'h11, 8'h09);
        wio(8'h21, 8'h01);
        wio(8'h10, 8'h03);                 // edge W
        rio(8'h10, 8'h03, "t0_w1");
        rio(8'h10, 8'h02, "t0_w2");
        rio(8'h10, 8'h02, "t0_w3_presc");
        idle(21);
        check("t0_irq_before", {15'd0, IRQ_n}, 16'h0001);
        idle(1);
        check("t0_irq_fall", {15'd0, IRQ_n}, 16'h0000);
        rio(8'h10, 8'hFF, "t0_wrap");
        rio(8'h10, 8'hFE, "t0_fast1");
        rio(8'h20, 8'h01, "t0_flag");
        wio(8'h11, 8'h00);                 // stop timer0
        wio(8'h20, 8'h01);
        check("t0_irq_clr", {15'd0, IRQ_n}, 16'h0001);
        rio(8'h10, 8'hFB, "t0_stopped");

        // ---------------- timer1 reload /1 -----------------------------
        wio(8'h21, 8'h02);
        wio(8'h15, 8'h0C);
        wio(8'h14, 8'h04);                 // edge V
        rio(8'h14, 8'h04, "t1_v1");
        rio(8'h14, 8'h03, "t1_v2");
        idle(2);
        rio(8'h20, 8'h00, "t1_flag_preset");
        rio(8'h20, 8'h02, "t1_flag_set");
        wio(8'h20, 8'h02);                 // V+7, no underflow
        check("t1_w1c_irq", {15'd0, IRQ_n}, 16'h0001);
        rio(8'h20, 8'h00, "t1_w1c_flag");
        rio(8'h14, 8'h01, "t1_reloaded");
        wio(8'h20, 8'h02);                 // V+10, coincides with underflow
        check("t1_setwins_irq", {15'd0, IRQ_n}, 16'h0000);
        rio(8'h20, 8'h02, "t1_setwins_flag");
        rio(8'h14, 8'h03, "t1_v12");
        idle(2);
        wio(8'h14, 8'h04);                 // V+15, CNT write on underflow
        check("t1_cntclr_irq", {15'd0, IRQ_n}, 16'h0001);
        rio(8'h20, 8'h00, "t1_cntclr_flag");
        rio(8'h14, 8'h03, "t1_cnt_beats_tick");
        wio(8'h15, 8'h04);                 // stop timer1
        wio(8'h21, 8'h00);

        // ---------------- ports ----------------------------------------
        wio(8'h00, 8'hA5);
        wio(8'h01, 8'hF0);
        check("p0_pout", P_out, 16'hFFAF);
        rio(8'h00, 8'hAF, "p0_read");
        ext_and = 16'hFFF7;
        rio(8'h00, 8'hA7, "p0_read_ext");
        ext_and = 16'hFFFF;
        rio(8'h01, 8'hF0, "p0_ddr");
        wio(8'h02, 8'h3C);
        wio(8'h03, 8'hFF);                 // port1 bit7 falls
        check("p1_pout", P_out, 16'h3CAF);
        rio(8'h02, 8'h3C, "p1_read");
        rio(8'h20, 8'h20, "p1_fall_flag");
        wio(8'h20, 8'h20);
        rio(8'h04, 8'h00, "unmapped_port");
        rio(8'h12, 8'h00, "unmapped_tmr");
        rio(8'h30, 8'h00, "unmapped_hi");

        // ---------------- edge detect ----------------------------------
        wio(8'h22, 8'h01);
        wio(8'h21, 8'h10);
        ext_and = 16'hFF7F;                // 1 -> 0, not a rising edge
        idle(2);
        check("edge_fall_irq", {15'd0, IRQ_n}, 16'h0001);
        rio(8'h20, 8'h00, "edge_fall_flag");
        ext_and = 16'hFFFF;                // 0 -> 1
        idle(2);
        check("edge_rise_irq", {15'd0, IRQ_n}, 16'h0000);
        rio(8'h20, 8'h10, "edge_rise_flag");
        wio(8'h20, 8'h10);
        check("edge_clr_irq", {15'd0, IRQ_n}, 16'h0001);

        // ---------------- RAM ------------------------------------------
        bus_wr(1'b0, 8'h05, 8'h5A);
        bus_wr(1'b0, 8'h7F, 8'hC3);
        bus_rd(1'b0, 8'h05, 8'h5A, "ram_05");
        bus_rd(1'b0, 8'h7F, 8'hC3, "ram_7f");
        bus_rd(1'b0, 8'h85, 8'h5A, "ram_alias");
        rio(8'h05, 8'h00, "io_not_ram");
        idle(1);
        check("dout_hold", {8'h00, d_out}, 16'h0000);

        // ---------------- mid-operation reset --------------------------
        wio(8'h11, 8'h08);
        wio(8'h21, 8'h01);
        wio(8'h10, 8'h00);
        idle(1);
        check("mr_irq_active", {15'd0, IRQ_n}, 16'h0000);
        rio(8'h01, 8'hF0, "mr_ddr_before");
        res_n = 1'b0;
        idle(1);
        check("mr_irq", {15'd0, IRQ_n}, 16'h0001);
        check("mr_pout", P_out, 16'hFFFF);
        check("mr_dout", {8'h00, d_out}, 16'h00FF);
        res_n = 1'b1; ce = 1'b0;
        rio(8'h10, 8'hFF, "mr_cnt0");
        rio(8'h11, 8'h0A, "mr_ctrl0");
        rio(8'h20, 8'h00, "mr_flag");
        rio(8'h21, 8'h00, "mr_ien");
        rio(8'h22, 8'h00, "mr_edge");
        rio(8'h01, 8'h00, "mr_ddr");
        bus_rd(1'b0, 8'h05, 8'h00, "mr_ram");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
